// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the RAM-side reader:
// bus widths, loader FSM encoding and a wrapping address helper.
package prog_loader_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loadState_e;

  // Both ROM and RAM address spaces are 256 bytes, so offsets simply wrap.
  function automatic addr_t wrapAdd(input addr_t base, input addr_t offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Copies 'length' bytes from a synchronous program ROM into the reader's RAM,
// keeps a running byte checksum and raises 'run' once the image is in place.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter addr_t ROM_BASE  = 8'h00,
  parameter addr_t LOAD_BASE = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] length,
  output logic [ADDR_W-1:0] romAddress,
  input  logic [DATA_W-1:0] romData,
  output logic [ADDR_W-1:0] ramAddress,
  output logic [DATA_W-1:0] ramValue,
  output logic              ramWrite,
  output logic              run,
  output logic              busy,
  output logic [DATA_W-1:0] checksum
);

  loadState_e stateQ, stateD;
  addr_t      idxQ, idxD;
  data_t      lenQ, lenD;
  data_t      checksumQ, checksumD;
  logic       wrValidQ;
  addr_t      wrIdxQ;
  data_t      ramValueQ;
  logic       accept;
  logic       lastFetch;

  assign accept    = start && ((stateQ == IDLE) || (stateQ == DONE));
  assign lastFetch = (idxQ == (lenQ - 8'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE, DONE: begin
        if (start) begin
          stateD = (length == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (lastFetch) begin
          stateD = DRAIN;
        end
      end
      DRAIN:   stateD = DONE;
      default: stateD = IDLE;
    endcase
  end

  // The index only moves while fetching, so romAddress naturally holds
  // outside FETCH; a zero-length start leaves it untouched.
  always_comb begin
    idxD      = idxQ;
    lenD      = lenQ;
    checksumD = checksumQ;
    if (accept && (length != '0)) begin
      idxD = '0;
      lenD = length;
    end else if ((stateQ == FETCH) && !lastFetch) begin
      idxD = idxQ + 8'd1;
    end
    if (accept) begin
      checksumD = '0;
    end else if (wrValidQ) begin
      checksumD = checksumQ + romData;
    end
  end

  // One pipeline stage lines the RAM address up with the ROM's read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idxQ      <= '0;
      lenQ      <= '0;
      checksumQ <= '0;
      wrValidQ  <= 1'b0;
      wrIdxQ    <= '0;
      ramValueQ <= '0;
    end else begin
      idxQ      <= idxD;
      lenQ      <= lenD;
      checksumQ <= checksumD;
      wrValidQ  <= (stateQ == FETCH);
      if (stateQ == FETCH) begin
        wrIdxQ <= idxQ;
      end
      if (wrValidQ) begin
        ramValueQ <= romData;
      end
    end
  end

  // ramValue forwards romData during a write and replays the last byte otherwise.
  always_comb begin
    busy       = (stateQ == FETCH) || (stateQ == DRAIN);
    run        = (stateQ == DONE);
    ramWrite   = wrValidQ;
    ramValue   = wrValidQ ? romData : ramValueQ;
    romAddress = wrapAdd(ROM_BASE, idxQ);
    ramAddress = wrapAdd(LOAD_BASE, wrIdxQ);
    checksum   = checksumQ;
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued when a load
// is started and matched against each ramWrite cycle as it appears.
module tb_prog_loader;

  localparam logic [7:0] ROM_BASE_A  = 8'h00;
  localparam logic [7:0] LOAD_BASE_A = 8'h00;
  localparam logic [7:0] ROM_BASE_B  = 8'hFE;
  localparam logic [7:0] LOAD_BASE_B = 8'hFC;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] value;
    int         cyc;
  } wrEntry_t;

  logic       clk;
  logic       reset;
  logic       start, startB;
  logic [7:0] length, lengthB;
  logic [7:0] romAddress, romAddressB;
  logic [7:0] romData, romDataB;
  logic [7:0] ramAddress, ramAddressB;
  logic [7:0] ramValue, ramValueB;
  logic       ramWrite, ramWriteB;
  logic       run, runB;
  logic       busy, busyB;
  logic [7:0] checksum, checksumB;

  logic [7:0] rom [256];
  wrEntry_t   sbQ[$];
  wrEntry_t   sbBQ[$];
  int         cycleNo    = 0;
  int         wrCount    = 0;
  int         wrCountB   = 0;
  int         vecCount   = 0;
  int         missCount  = 0;

  prog_loader #(.ROM_BASE(ROM_BASE_A), .LOAD_BASE(LOAD_BASE_A)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .romAddress(romAddress), .romData(romData),
    .ramAddress(ramAddress), .ramValue(ramValue), .ramWrite(ramWrite),
    .run(run), .busy(busy), .checksum(checksum)
  );

  prog_loader #(.ROM_BASE(ROM_BASE_B), .LOAD_BASE(LOAD_BASE_B)) dutWrap (
    .clk(clk), .reset(reset), .start(startB), .length(lengthB),
    .romAddress(romAddressB), .romData(romDataB),
    .ramAddress(ramAddressB), .ramValue(ramValueB), .ramWrite(ramWriteB),
    .run(runB), .busy(busyB), .checksum(checksumB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo = cycleNo + 1;

  // Program ROM model with one cycle of read latency.
  always @(posedge clk) begin
    romData  <= rom[romAddress];
    romDataB <= rom[romAddressB];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycleNo);
    end
  endtask

  always @(negedge clk) begin
    wrEntry_t e;
    if (ramWrite) begin
      wrCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpWr", 32'(ramWrite), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("wrAddr", 32'(ramAddress), 32'(e.addr));
        checkOutput("wrData", 32'(ramValue), 32'(e.value));
        checkOutput("wrCyc", 32'(cycleNo), 32'(e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    wrEntry_t e;
    if (ramWriteB) begin
      wrCountB++;
      if (sbBQ.size() == 0) begin
        checkOutput("unexpWrB", 32'(ramWriteB), 32'd0);
      end else begin
        e = sbBQ.pop_front();
        checkOutput("wrAddrB", 32'(ramAddressB), 32'(e.addr));
        checkOutput("wrDataB", 32'(ramValueB), 32'(e.value));
        checkOutput("wrCycB", 32'(cycleNo), 32'(e.cyc));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".romAddr"}, 32'(romAddress), 32'(ROM_BASE_A));
    checkOutput({tag, ".ramAddr"}, 32'(ramAddress), 32'(LOAD_BASE_A));
    checkOutput({tag, ".ramValue"}, 32'(ramValue), 32'd0);
    checkOutput({tag, ".ramWrite"}, 32'(ramWrite), 32'd0);
    checkOutput({tag, ".run"}, 32'(run), 32'd0);
    checkOutput({tag, ".busy"}, 32'(busy), 32'd0);
    checkOutput({tag, ".checksum"}, 32'(checksum), 32'd0);
  endtask

  // Runs one load on the main DUT. Called at a falling edge. glitchAt drives a
  // second start (length 3) in that cycle; resetAt pulses reset from that cycle.
  task automatic applyStimulus(input int len, input int glitchAt, input int resetAt);
    int         nWrites;
    int         last;
    logic [7:0] expSum;
    logic [7:0] a;
    logic       expBusy;
    logic       expRun;
    nWrites = len;
    if ((resetAt > 0) && (resetAt - 2 < len)) nWrites = resetAt - 2;
    expSum  = 8'd0;
    wrCount = 0;
    for (int i = 0; i < nWrites; i++) begin
      a = 8'(ROM_BASE_A + i);
      expSum += rom[a];
      sbQ.push_back('{addr: 8'(LOAD_BASE_A + i), value: rom[a], cyc: cycleNo + 2 + i});
    end
    last   = (resetAt > 0) ? resetAt + 4 : len + 3;
    start  = 1'b1;
    length = 8'(len);
    for (int n = 1; n <= last; n++) begin
      @(posedge clk);
      if (n == resetAt) begin
        #1 reset = 1'b1;
      end
      @(negedge clk);
      if ((resetAt > 0) && (n >= resetAt)) begin
        checkResetValues("abort");
      end else begin
        expBusy = (len != 0) && (n <= len + 1);
        expRun  = (len == 0) || (n >= len + 2);
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("run", 32'(run), 32'(expRun));
        if ((len != 0) && (n <= len)) begin
          checkOutput("romAddr", 32'(romAddress), 32'(8'(ROM_BASE_A + n - 1)));
        end
      end
      start  = (n == glitchAt);
      length = (n == glitchAt) ? 8'd3 : 8'(len);
      if ((resetAt > 0) && (n == resetAt + 1)) reset = 1'b0;
    end
    start = 1'b0;
    if (resetAt == 0) checkOutput("checksum", 32'(checksum), 32'(expSum));
    checkOutput("wrCount", 32'(wrCount), 32'(nWrites));
    checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
  endtask

  // Load on the wrapping-base DUT; both address spaces cross 8'hFF.
  task automatic applyWrapStimulus(input int len);
    logic [7:0] expSum;
    logic [7:0] a;
    expSum   = 8'd0;
    wrCountB = 0;
    for (int i = 0; i < len; i++) begin
      a = 8'(ROM_BASE_B + i);
      expSum += rom[a];
      sbBQ.push_back('{addr: 8'(LOAD_BASE_B + i), value: rom[a], cyc: cycleNo + 2 + i});
    end
    startB  = 1'b1;
    lengthB = 8'(len);
    @(negedge clk);
    startB = 1'b0;
    for (int n = 2; n <= len + 3; n++) @(negedge clk);
    checkOutput("runB", 32'(runB), 32'd1);
    checkOutput("checksumB", 32'(checksumB), 32'(expSum));
    checkOutput("wrCountB", 32'(wrCountB), 32'(len));
    checkOutput("sbBEmpty", 32'(sbBQ.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = (i < 20) ? 8'(i + 1) : 8'((i * 7 + 3) & 8'hFF);
    end
    reset   = 1'b1;
    start   = 1'b0;
    startB  = 1'b0;
    length  = 8'd0;
    lengthB = 8'd0;
    repeat (2) @(negedge clk);
    checkResetValues("reset");
    checkOutput("reset.romAddrB", 32'(romAddressB), 32'(ROM_BASE_B));
    checkOutput("reset.ramAddrB", 32'(ramAddressB), 32'(LOAD_BASE_B));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] 20-byte load");
    applyStimulus(20, 0, 0);
    checkOutput("sum20", 32'(checksum), 32'h0000_00D2);
    checkOutput("holdAddr", 32'(ramAddress), 32'h0000_0013);
    checkOutput("holdValue", 32'(ramValue), 32'h0000_0014);

    $display("[TB] zero-length load");
    applyStimulus(0, 0, 0);

    $display("[TB] start while busy is ignored");
    applyStimulus(20, 5, 0);

    $display("[TB] restart from DONE");
    applyStimulus(3, 0, 0);

    $display("[TB] wrapping addresses");
    applyWrapStimulus(6);
    checkOutput("wrapHold", 32'(ramAddressB), 32'h0000_0001);

    $display("[TB] reset in mid-load");
    applyStimulus(20, 0, 8);

    $display("[TB] fresh load after abort");
    applyStimulus(5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ROM_BASE, default 8'h00: first source byte address in the program ROM.
REQ-002 Parameter LOAD_BASE, default 8'h00: first destination address in the reader's RAM.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle load request; sampled on rising clk.
REQ-006 length  input  8  number of bytes to transfer (0-255); sampled with start.
REQ-007 romAddress  output  8  program ROM read address.
REQ-008 romData  input  8  ROM read data, valid the cycle after romAddress is presented (1-cycle synchronous read).
REQ-009 ramAddress  output  8  destination address to reader.
REQ-010 ramValue  output  8  destination byte to reader.
REQ-011 ramWrite  output  1  qualifies ramAddress/ramValue; one byte per high cycle.
REQ-012 run  output  1  tells reader the program is loaded and execution may begin.
REQ-013 busy  output  1  high while a load is in progress.
REQ-014 checksum  output  8  modulo-256 sum of all bytes written in the current or last load.

Function
REQ-015 FSM states: IDLE, FETCH, DRAIN, DONE.
REQ-016 IDLE: start with length!=0 -> FETCH; start with length==0 -> DONE; no start -> stay.
REQ-017 The edge that accepts start is edge 0; the cycle after it is cycle 1.
REQ-018 FETCH presents romAddress = ROM_BASE+i for i = 0..length-1, one per cycle, cycles 1..length.
REQ-019 ramWrite is high in cycles 2..length+1, with ramAddress = LOAD_BASE+i and ramValue = the romData returned for ROM_BASE+i.
REQ-020 After issuing the last ROM address, FETCH -> DRAIN for one cycle (last write), then DRAIN -> DONE.
REQ-021 run is high from cycle length+2 (cycle 1 for length==0) and stays high while in DONE.
REQ-022 busy is high in FETCH and DRAIN only.
REQ-023 checksum clears on accepted start and adds ramValue on every ramWrite cycle; it is stable once run is high.
REQ-024 All address arithmetic is 8-bit and wraps modulo 256, on both ROM and RAM sides.
REQ-025 start while busy is ignored; length is not re-sampled.
REQ-026 start in DONE restarts: run drops in cycle 1 and a new load runs under REQ-016..REQ-023.
REQ-027 ramAddress/ramValue hold their last written values when ramWrite is low.
REQ-028 romAddress holds its last value outside FETCH.

Reset
REQ-029 While reset is high: state=IDLE, romAddress=ROM_BASE, ramAddress=LOAD_BASE, ramValue=0, ramWrite=0, run=0, busy=0, checksum=0.
REQ-030 Reset asserted mid-load aborts immediately with no further ramWrite; the next load needs a fresh start.

Structure
REQ-031 The FSM state encoding and the 8-bit address/data width constants live in a shared package used by prog_loader and reader.
REQ-032 prog_loader is a single module: one index counter, one write-pipeline register stage and the FSM; no sub-module is warranted.

Verification
REQ-033 ROM[0..19] = 8'h01..8'h14, start with length=20 -> 20 writes in cycles 2..21 to addresses 00..13 carrying 01..14, run high from cycle 22, checksum=8'hD2.
REQ-034 start with length=0 -> no ramWrite, busy never high, run high in cycle 1, checksum=00.
REQ-035 LOAD_BASE=8'hFC, length=6 -> ramAddress sequence FC,FD,FE,FF,00,01.
REQ-036 length=20, reset pulsed in cycle 8 -> ramWrite low from the reset edge onward, outputs at reset values, run stays 0.
REQ-037 length=20, second start in cycle 5 with length=3 -> ignored, exactly 20 writes; then start with length=3 in DONE -> run low in cycle 1, 3 writes, run high again in cycle 5.
